// File: rtl/csr_file_if.sv
// CSR access bus: combinational ID read port plus the committed WB write port.
interface csr_file_if;
   logic [11:0] csr_raddr_i;
   logic [31:0] csr_rdata_o;
   logic        wb_csr_write_i;
   logic [11:0] wb_csr_waddr_i;
   logic [31:0] wb_csr_wdata_i;

   modport master (
      output csr_raddr_i, wb_csr_write_i, wb_csr_waddr_i, wb_csr_wdata_i,
      input  csr_rdata_o
   );

   modport slave (
      input  csr_raddr_i, wb_csr_write_i, wb_csr_waddr_i, wb_csr_wdata_i,
      output csr_rdata_o
   );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file with 64-bit counters and the interrupt / WFI controller.
module csr_file #(
   parameter logic [31:0] MTVEC_VAL = 32'h0000_1000
) (
   input  logic        clk,
   input  logic        rstn,
   csr_file_if.slave   bus,
   input  logic        wb_retire_i,
   input  logic        ex_valid_i,
   input  logic [31:0] ex_pc_i,
   input  logic        ex_mret_i,
   input  logic        ex_wfi_i,
   input  logic        ext_irq_i,
   input  logic        timer_irq_i,
   output logic        irq_take_o,
   output logic [31:0] trap_vec_o,
   output logic [31:0] mepc_o,
   output logic        wfi_stall_o
);

   typedef enum logic {RUN, SLEEP} state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_mst_mie;
   logic        r_mst_mpie;
   logic        r_mie_mtie;
   logic        r_mie_meie;
   logic        r_mip_mtip;
   logic        r_mip_meip;
   logic [31:0] r_mepc;
   logic [31:0] r_wfi_pc;
   logic [63:0] r_mcycle;
   logic [63:0] r_minstret;

   logic        w_pend;
   logic        w_take_ok;
   logic        w_take;
   logic        w_mret;
   logic        w_stall;
   logic [31:0] w_trap_pc;
   logic [31:0] w_rval;
   logic [31:0] w_wval;
   logic        w_wok;
   logic        w_we;
   logic [31:0] w_wd;

   assign w_we = bus.wb_csr_write_i;
   assign w_wd = bus.wb_csr_wdata_i;

   assign w_pend    = (r_mip_mtip & r_mie_mtie) | (r_mip_meip & r_mie_meie);
   assign w_take_ok = w_pend & r_mst_mie;

   // Masked image of the WB write; w_wok marks writable addresses.
   always_comb begin
      w_wval = 32'h0;
      w_wok  = 1'b0;
      unique case (bus.wb_csr_waddr_i)
         12'h300: begin
            w_wval = {19'h0, 2'b11, 3'h0, w_wd[7], 3'h0, w_wd[3], 3'h0};
            w_wok  = 1'b1;
         end
         12'h304: begin
            w_wval = {20'h0, w_wd[11], 3'h0, w_wd[7], 7'h0};
            w_wok  = 1'b1;
         end
         12'h341: begin
            w_wval = {w_wd[31:2], 2'b00};
            w_wok  = 1'b1;
         end
         12'hB00, 12'hB80, 12'hB02, 12'hB82: begin
            w_wval = w_wd;
            w_wok  = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      w_rval = 32'h0;
      unique case (bus.csr_raddr_i)
         12'h300: w_rval = {19'h0, 2'b11, 3'h0, r_mst_mpie, 3'h0, r_mst_mie, 3'h0};
         12'h304: w_rval = {20'h0, r_mie_meie, 3'h0, r_mie_mtie, 7'h0};
         12'h305: w_rval = MTVEC_VAL;
         12'h341: w_rval = r_mepc;
         12'h344: w_rval = {20'h0, r_mip_meip, 3'h0, r_mip_mtip, 7'h0};
         12'hB00, 12'hC00: w_rval = r_mcycle[31:0];
         12'hB80, 12'hC80: w_rval = r_mcycle[63:32];
         12'hB02, 12'hC02: w_rval = r_minstret[31:0];
         12'hB82, 12'hC82: w_rval = r_minstret[63:32];
         default: ;
      endcase
   end

   assign bus.csr_rdata_o =
      (w_we && w_wok && bus.wb_csr_waddr_i == bus.csr_raddr_i) ? w_wval : w_rval;

   always_comb begin
      w_next    = r_state;
      w_take    = 1'b0;
      w_mret    = 1'b0;
      w_stall   = 1'b0;
      w_trap_pc = ex_wfi_i ? ex_pc_i + 32'd4 : ex_pc_i;
      unique case (r_state)
         RUN: begin
            if (ex_valid_i && w_take_ok) begin
               w_take = 1'b1;
            end else if (ex_valid_i && ex_mret_i) begin
               w_mret = 1'b1;
            end else if (ex_valid_i && ex_wfi_i && !w_pend) begin
               w_next = SLEEP;
            end
         end
         SLEEP: begin
            w_stall   = 1'b1;
            w_trap_pc = r_wfi_pc;
            if (w_pend) begin
               w_take = r_mst_mie;
               w_next = RUN;
            end
         end
         default: w_next = RUN;
      endcase
   end

   assign irq_take_o  = w_take;
   assign wfi_stall_o = w_stall;
   assign trap_vec_o  = MTVEC_VAL;
   assign mepc_o      = r_mepc;

   // Trap and mret updates to MIE/MPIE/mepc take priority over a WB write.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state    <= RUN;
         r_mst_mie  <= 1'b0;
         r_mst_mpie <= 1'b0;
         r_mie_mtie <= 1'b0;
         r_mie_meie <= 1'b0;
         r_mip_mtip <= 1'b0;
         r_mip_meip <= 1'b0;
         r_mepc     <= 32'h0;
         r_wfi_pc   <= 32'h0;
         r_mcycle   <= 64'h0;
         r_minstret <= 64'h0;
      end else begin
         r_state    <= w_next;
         r_mip_mtip <= timer_irq_i;
         r_mip_meip <= ext_irq_i;
         if (r_state == RUN && w_next == SLEEP)
            r_wfi_pc <= ex_pc_i + 32'd4;
         if (w_take) begin
            r_mst_mpie <= r_mst_mie;
            r_mst_mie  <= 1'b0;
         end else if (w_mret) begin
            r_mst_mie  <= r_mst_mpie;
            r_mst_mpie <= 1'b1;
         end else if (w_we && bus.wb_csr_waddr_i == 12'h300) begin
            r_mst_mie  <= w_wd[3];
            r_mst_mpie <= w_wd[7];
         end
         if (w_take)
            r_mepc <= {w_trap_pc[31:2], 2'b00};
         else if (w_we && bus.wb_csr_waddr_i == 12'h341)
            r_mepc <= {w_wd[31:2], 2'b00};
         if (w_we && bus.wb_csr_waddr_i == 12'h304) begin
            r_mie_mtie <= w_wd[7];
            r_mie_meie <= w_wd[11];
         end
         if (w_we && bus.wb_csr_waddr_i == 12'hB00)
            r_mcycle[31:0] <= w_wd;
         else if (w_we && bus.wb_csr_waddr_i == 12'hB80)
            r_mcycle[63:32] <= w_wd;
         else
            r_mcycle <= r_mcycle + 64'd1;
         if (w_we && bus.wb_csr_waddr_i == 12'hB02)
            r_minstret[31:0] <= w_wd;
         else if (w_we && bus.wb_csr_waddr_i == 12'hB82)
            r_minstret[63:32] <= w_wd;
         else if (wb_retire_i)
            r_minstret <= r_minstret + 64'd1;
      end
   end

endmodule

// File: tb/tb_csr_file.sv
// Scoreboarded bench for csr_file: expectations queued at drive, checked mid-cycle.
module tb_csr_file;

   localparam int RD   = 0;
   localparam int TAKE = 1;
   localparam int STL  = 2;
   localparam int MEPC = 3;
   localparam int TVEC = 4;

   logic        clk = 1'b0;
   logic        rstn;
   logic        wb_retire_i;
   logic        ex_valid_i;
   logic [31:0] ex_pc_i;
   logic        ex_mret_i;
   logic        ex_wfi_i;
   logic        ext_irq_i;
   logic        timer_irq_i;
   logic        irq_take_o;
   logic [31:0] trap_vec_o;
   logic [31:0] mepc_o;
   logic        wfi_stall_o;

   int n_chk = 0;
   int n_err = 0;

   int          sel_q[$];
   logic [31:0] val_q[$];
   string       tag_q[$];

   csr_file_if bus ();

   csr_file #(.MTVEC_VAL(32'h0000_1000)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .bus         (bus.slave),
      .wb_retire_i (wb_retire_i),
      .ex_valid_i  (ex_valid_i),
      .ex_pc_i     (ex_pc_i),
      .ex_mret_i   (ex_mret_i),
      .ex_wfi_i    (ex_wfi_i),
      .ext_irq_i   (ext_irq_i),
      .timer_irq_i (timer_irq_i),
      .irq_take_o  (irq_take_o),
      .trap_vec_o  (trap_vec_o),
      .mepc_o      (mepc_o),
      .wfi_stall_o (wfi_stall_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic push(input int s, input logic [31:0] v, input string t);
      sel_q.push_back(s);
      val_q.push_back(v);
      tag_q.push_back(t);
   endtask

   // Outputs are sampled on the falling edge, mid decision cycle.
   int          c_sel;
   logic [31:0] c_obs;
   always @(negedge clk) begin
      while (sel_q.size() > 0) begin
         c_sel = sel_q.pop_front();
         case (c_sel)
            RD:      c_obs = bus.csr_rdata_o;
            TAKE:    c_obs = {31'h0, irq_take_o};
            STL:     c_obs = {31'h0, wfi_stall_o};
            MEPC:    c_obs = mepc_o;
            default: c_obs = trap_vec_o;
         endcase
         chk(tag_q.pop_front(), c_obs, val_q.pop_front());
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      bus.wb_csr_write_i = 1'b0;
      ex_valid_i  = 1'b0;
      ex_mret_i   = 1'b0;
      ex_wfi_i    = 1'b0;
      wb_retire_i = 1'b0;
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      bus.wb_csr_write_i = 1'b1;
      bus.wb_csr_waddr_i = a;
      bus.wb_csr_wdata_i = d;
   endtask

   task automatic ex(input logic [31:0] pc, input logic m, input logic w);
      ex_valid_i = 1'b1;
      ex_pc_i    = pc;
      ex_mret_i  = m;
      ex_wfi_i   = w;
   endtask

   task automatic rd(input logic [11:0] a, input logic [31:0] v, input string t);
      bus.csr_raddr_i = a;
      push(RD, v, t);
   endtask

   initial begin
      rstn = 1'b0;
      wb_retire_i = 1'b0;
      ex_valid_i = 1'b0;
      ex_pc_i = 32'h0;
      ex_mret_i = 1'b0;
      ex_wfi_i = 1'b0;
      ext_irq_i = 1'b0;
      timer_irq_i = 1'b0;
      bus.csr_raddr_i = 12'h0;
      bus.wb_csr_write_i = 1'b0;
      bus.wb_csr_waddr_i = 12'h0;
      bus.wb_csr_wdata_i = 32'h0;
      cyc();
      push(STL, 0, "rst_stall");
      push(TAKE, 0, "rst_take");
      rd(12'h300, 32'h1800, "rst_mstatus");
      cyc();
      rd(12'h344, 32'h0, "rst_mip");
      cyc();
      rstn = 1'b1;
      repeat (10) cyc();
      rd(12'hC00, 32'd10, "mcycle10");
      push(TAKE, 0, "idle_take");
      cyc();
      rd(12'hB80, 32'h0, "mcycleh0");
      cyc();
      rd(12'hB02, 32'h0, "minstret0");
      cyc();
      // CSR write masking, bypass and read-only aliases
      wr(12'h300, 32'hFFFF_FFFF);
      rd(12'h300, 32'h1888, "byp_mstatus");
      cyc();
      rd(12'h300, 32'h1888, "mstatus_wr");
      cyc();
      wr(12'hC80, 32'hDEAD);
      rd(12'hC80, 32'h0, "ro_no_byp");
      cyc();
      rd(12'hB80, 32'h0, "ro_ignored");
      cyc();
      wr(12'h305, 32'h0);
      rd(12'h305, 32'h1000, "mtvec");
      push(TVEC, 32'h1000, "trap_vec");
      cyc();
      wr(12'h341, 32'hFFFF_FFFF);
      rd(12'h341, 32'hFFFF_FFFC, "mepc_mask");
      cyc();
      wr(12'h304, 32'hFFFF_FFFF);
      rd(12'h304, 32'h880, "mie_mask");
      cyc();
      wr(12'h304, 32'h800);
      cyc();
      rd(12'h304, 32'h800, "mie_meie");
      cyc();
      // external interrupt, then mret
      ext_irq_i = 1'b1;
      ex(32'h200, 1'b0, 1'b0);
      push(TAKE, 0, "irq_latency");
      cyc();
      ex(32'h200, 1'b0, 1'b0);
      push(TAKE, 1, "irq_take");
      push(MEPC, 32'hFFFF_FFFC, "mepc_pre");
      cyc();
      ext_irq_i = 1'b0;
      ex(32'h204, 1'b0, 1'b0);
      push(TAKE, 0, "no_back2back");
      push(MEPC, 32'h200, "irq_mepc");
      rd(12'h300, 32'h1880, "mstatus_trap");
      cyc();
      ex(32'h220, 1'b1, 1'b0);
      push(TAKE, 0, "mret_take");
      push(MEPC, 32'h200, "mret_tgt");
      cyc();
      rd(12'h300, 32'h1888, "mstatus_mret");
      cyc();
      // wfi woken by timer with MIE=1
      wr(12'h304, 32'h880);
      cyc();
      ex(32'h300, 1'b0, 1'b1);
      push(STL, 0, "wfi_edge");
      cyc();
      ex(32'h300, 1'b0, 1'b1);
      push(STL, 1, "sleep");
      cyc();
      timer_irq_i = 1'b1;
      push(STL, 1, "sleep_irq");
      push(TAKE, 0, "sleep_lat");
      cyc();
      timer_irq_i = 1'b0;
      push(TAKE, 1, "wake_take");
      push(STL, 1, "wake_stall");
      cyc();
      push(STL, 0, "wake_rel");
      push(MEPC, 32'h304, "wfi_mepc");
      rd(12'h300, 32'h1880, "mstatus_wfi");
      cyc();
      // wfi woken with MIE=0
      ex(32'h400, 1'b0, 1'b1);
      push(STL, 0, "wfi2_edge");
      cyc();
      push(STL, 1, "sleep2");
      cyc();
      timer_irq_i = 1'b1;
      push(STL, 1, "sleep2_irq");
      cyc();
      rd(12'h344, 32'h80, "mip_mtip");
      push(TAKE, 0, "wake_notrap");
      push(STL, 1, "wake2_stall");
      cyc();
      push(STL, 0, "wake2_rel");
      push(MEPC, 32'h304, "mepc_kept");
      cyc();
      ex(32'h500, 1'b0, 1'b1);
      push(TAKE, 0, "nop_take");
      push(STL, 0, "nop_edge");
      cyc();
      timer_irq_i = 1'b0;
      push(STL, 0, "wfi_nop");
      cyc();
      // 64-bit wrap
      wr(12'hB00, 32'hFFFF_FFFF);
      cyc();
      wr(12'hB80, 32'hFFFF_FFFF);
      cyc();
      rd(12'hB00, 32'hFFFF_FFFF, "cyc_max");
      cyc();
      rd(12'hB00, 32'h0, "wrap_lo");
      cyc();
      rd(12'hB80, 32'h0, "wrap_hi");
      cyc();
      wr(12'hB02, 32'd5);
      wb_retire_i = 1'b1;
      cyc();
      wb_retire_i = 1'b1;
      cyc();
      rd(12'hC02, 32'd6, "instret");
      cyc();
      // mret racing an interrupt, with a competing mepc write
      wr(12'h300, 32'h8);
      ext_irq_i = 1'b1;
      cyc();
      ext_irq_i = 1'b0;
      ex(32'h600, 1'b1, 1'b0);
      wr(12'h341, 32'h1234);
      push(TAKE, 1, "mret_vs_irq");
      cyc();
      push(MEPC, 32'h600, "trap_wins");
      rd(12'h300, 32'h1880, "mstatus_tw");
      cyc();
      // reset while sleeping
      ex(32'h700, 1'b0, 1'b1);
      cyc();
      push(STL, 1, "sleep3");
      rstn = 1'b0;
      cyc();
      push(STL, 0, "rst_sleep");
      rd(12'h341, 32'h0, "rst_mepc");
      cyc();
      rd(12'h304, 32'h0, "rst_mie");
      cyc();
      rstn = 1'b1;
      cyc();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/csr_file.md
# csr_file

Machine-mode CSR register file and interrupt/WFI controller for the 5-stage RV32 core. It receives committed CSR writes from WB, serves combinational CSR reads to ID, and runs the 64-bit cycle and instret counters. It decides interrupt entry, `mret` return and WFI sleep for the instruction in EX, and drives the interrupt/flush request and target PCs that EX consumes.

## Interface
- `MTVEC_VAL`, default 32'h0000_1000: constant trap vector; read value of `mtvec`.
- `clk` in 1: clock.
- `rstn` in 1: synchronous active-low reset.
- `csr_raddr_i` in 12: ID read address.
- `csr_rdata_o` out 32: combinational read data.
- `wb_csr_write_i` in 1: WB CSR write enable.
- `wb_csr_waddr_i` in 12: WB write address.
- `wb_csr_wdata_i` in 32: WB write data, already computed by the EX CSR ALU.
- `wb_retire_i` in 1: one instruction retired this cycle.
- `ex_valid_i` in 1: EX holds a real (non-bubble) instruction.
- `ex_pc_i` in 32: PC of the instruction in EX.
- `ex_mret_i` in 1: EX instruction is `mret`.
- `ex_wfi_i` in 1: EX instruction is `wfi`.
- `ext_irq_i` in 1: DMA/EPU external interrupt, level.
- `timer_irq_i` in 1: timer interrupt, level.
- `irq_take_o` out 1: take trap this cycle; EX flushes and jumps to `trap_vec_o`.
- `trap_vec_o` out 32: always `MTVEC_VAL`.
- `mepc_o` out 32: current `mepc`; `mret` target.
- `wfi_stall_o` out 1: freeze IF/ID/EX while sleeping.

## Operation
- CSR map. Unlisted addresses read 0. Writes to unlisted or read-only addresses are ignored.
  - `mstatus` 0x300: only MIE[3] and MPIE[7] are writable. MPP[12:11] is hardwired to 2'b11. All other bits read 0.
  - `mie` 0x304: only MTIE[7] and MEIE[11] are writable.
  - `mtvec` 0x305: read-only, reads `MTVEC_VAL`.
  - `mepc` 0x341: bits [31:2] are writable; bits [1:0] read 0.
  - `mip` 0x344: read-only. MTIP[7] is `timer_irq_i` registered one cycle; MEIP[11] is `ext_irq_i` registered one cycle.
  - Counters: `mcycle`/`mcycleh` 0xB00/0xB80 and `minstret`/`minstreth` 0xB02/0xB82 are writable. Aliases `cycle`/`cycleh` 0xC00/0xC80 and `instret`/`instreth` 0xC02/0xC82 are read-only.
- Read bypass: if `wb_csr_write_i` is high and `wb_csr_waddr_i` equals `csr_raddr_i`, `csr_rdata_o` returns the masked write value, not the old value.
- Counters:
  - `mcycle` increments by 1 every cycle.
  - `minstret` increments by 1 when `wb_retire_i` is high.
  - Both wrap from 2^64-1 to 0. Carry from the low half into the high half happens in the same cycle.
  - A WB write to either half overrides that counter's increment in that cycle.
- `pend` = (`mip` & `mie`) != 0. `take_ok` = `pend` && `mstatus.MIE`.
- FSM states: RUN, SLEEP.
  - RUN, `ex_valid_i` && `take_ok`: assert `irq_take_o`.
    - `mepc` <= `ex_pc_i` (or `ex_pc_i`+4 if `ex_wfi_i`).
    - MPIE <= MIE; MIE <= 0.
    - Stay in RUN.
    - Any `mret` or `wfi` in EX is suppressed.
  - RUN, `ex_valid_i` && `ex_mret_i` (no take): MIE <= MPIE; MPIE <= 1. EX redirects to `mepc_o`.
  - RUN, `ex_valid_i` && `ex_wfi_i` && !`pend`: go to SLEEP and latch `wfi_pc` <= `ex_pc_i`+4.
  - RUN, `ex_valid_i` && `ex_wfi_i` && `pend` && !MIE: `wfi` behaves as a NOP.
  - SLEEP: `wfi_stall_o`=1.
    - On `pend` && MIE: assert `irq_take_o`, `mepc` <= `wfi_pc`, update MIE/MPIE as for a trap, go to RUN.
    - On `pend` && !MIE: go to RUN with no trap; the pipeline resumes after the `wfi`.
- Write priority per register, same edge: trap/`mret` updates to MIE, MPIE and `mepc` win over a WB write. The WB write still applies to all other fields and registers.

## Timing
- Reset values (`rstn`=0 at a clock edge):
  - `mstatus` = 32'h0000_1800; `mie` = `mip` = `mepc` = 0; counters = 0.
  - FSM = RUN; `irq_take_o` = 0; `wfi_stall_o` = 0.
  - Reset mid-SLEEP returns the FSM to RUN.
- `csr_rdata_o`, `irq_take_o`, `mepc_o`, `trap_vec_o`: combinational in the decision cycle T. State updates at the end of T.
- Interrupt latency: an irq line rising in cycle T sets `mip` at edge T. The earliest `irq_take_o` is cycle T+1.
- `wfi_stall_o` is high from the cycle after the WFI edge, through the wake cycle inclusive.
- `irq_take_o` is never high two consecutive cycles, because MIE is cleared at the end of the take cycle.

## Test plan
- Reset, then idle 10 cycles -> `mstatus` reads 0x1800; `mcycle` reads 10 (±reset-edge definition, documented); `irq_take_o`=0.
- WB writes 0xFFFF_FFFF to `mstatus`, then reads it -> 0x0000_1888. Same-cycle read of 0x300 -> 0x1888 via bypass. Write to 0xC00 -> ignored.
- `mie`=0x800, MIE=1, `ext_irq_i` high at T, EX valid with pc 0x200 -> `irq_take_o` at T+1; `mepc`=0x200; MIE=0; MPIE=1. Next `mret` -> target 0x200 and MIE=1.
- `wfi` at pc 0x300 with nothing pending -> `wfi_stall_o` high. `timer_irq_i` with MTIE=1, MIE=1 -> trap, `mepc`=0x304, stall released.
- Same `wfi`, but MIE=0 -> wakes with no `irq_take_o`; stall drops. Also check the `wfi` NOP case when an interrupt is already pending.
- WB writes `mcycle`=0xFFFF_FFFF and `mcycleh`=0xFFFF_FFFF -> the next cycle reads 0 in both halves. A `mret` and an interrupt in the same cycle -> the trap wins and `mepc` = the `mret` PC.
